// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: op codes, aluop classes,
// opcodes, Type-C func bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_NOT   = 3'd4,
    ALU_PASSA = 3'd5,
    ALU_PASSB = 3'd6,
    ALU_MUL   = 3'd7
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_TYPEC = 2'b10;
  localparam logic [1:0] ALUOP_TYPED = 2'b11;

  localparam logic [3:0] OPC_JUMP = 4'b0010;
  localparam logic [3:0] OPC_BRZ  = 4'b0100;
  localparam logic [3:0] OPC_ADDI = 4'b1100;
  localparam logic [3:0] OPC_SUBI = 4'b1101;
  localparam logic [3:0] OPC_ANDI = 4'b1110;
  localparam logic [3:0] OPC_ORI  = 4'b1111;

  localparam int FUNC_PASSA_BIT = 0;
  localparam int FUNC_PASSB_BIT = 1;
  localparam int FUNC_ADD_BIT   = 2;
  localparam int FUNC_SUB_BIT   = 3;
  localparam int FUNC_AND_BIT   = 4;
  localparam int FUNC_OR_BIT    = 5;
  localparam int FUNC_NOT_BIT   = 6;
  localparam int FUNC_MUL_BIT   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control: maps aluop/opcode/func to a 3-bit operation.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int FUNC_W     = 9,
  parameter int ENABLE_MUL = 1
) (
  input  logic [1:0]        aluop,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  output alu_op_e           op
);

  generate
    if (FUNC_W > 8) begin : g_func_hi
      logic unused_func_hi;
      assign unused_func_hi = ^func[FUNC_W-1:8];
    end
  endgenerate

  always_comb begin
    op = ALU_ADD;
    case (aluop)
      ALUOP_MEM: begin
        if (opcode == OPC_W'(OPC_JUMP) || opcode == OPC_W'(OPC_BRZ)) op = ALU_PASSB;
      end
      ALUOP_BR: op = ALU_SUB;
      ALUOP_TYPEC: begin
        // Fixed priority; an empty or undriven field falls through to ADD
        if      (func[FUNC_ADD_BIT] == 1'b1)                     op = ALU_ADD;
        else if (func[FUNC_SUB_BIT] == 1'b1)                     op = ALU_SUB;
        else if (func[FUNC_AND_BIT] == 1'b1)                     op = ALU_AND;
        else if (func[FUNC_OR_BIT]  == 1'b1)                     op = ALU_OR;
        else if (func[FUNC_NOT_BIT] == 1'b1)                     op = ALU_NOT;
        else if (ENABLE_MUL != 0 && func[FUNC_MUL_BIT] == 1'b1)  op = ALU_MUL;
        else if (func[FUNC_PASSB_BIT] == 1'b1)                   op = ALU_PASSB;
        else if (func[FUNC_PASSA_BIT] == 1'b1)                   op = ALU_PASSA;
        else                                                     op = ALU_ADD;
      end
      default: begin
        if      (opcode == OPC_W'(OPC_SUBI)) op = ALU_SUB;
        else if (opcode == OPC_W'(OPC_ANDI)) op = ALU_AND;
        else if (opcode == OPC_W'(OPC_ORI))  op = ALU_OR;
        else                                 op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit with an iterative shift-add unsigned multiplier
// and a start/busy/done handshake towards the main control FSM.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int OPC_W      = 4,
  parameter int FUNC_W     = 9,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        aluop,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  hi,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_op_e              op;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     result_q, hi_q, alu_d;
  logic                 zero_q;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   prod_d;

  alu_op_decode #(
    .OPC_W     (OPC_W),
    .FUNC_W    (FUNC_W),
    .ENABLE_MUL(ENABLE_MUL)
  ) u_decode (
    .aluop (aluop),
    .opcode(opcode),
    .func  (func),
    .op    (op)
  );

  always_comb begin
    case (op)
      ALU_SUB:   alu_d = a - b;
      ALU_AND:   alu_d = a & b;
      ALU_OR:    alu_d = a | b;
      ALU_NOT:   alu_d = ~a;
      ALU_PASSA: alu_d = a;
      ALU_PASSB: alu_d = b;
      default:   alu_d = a + b;
    endcase
  end

  // prod_q = {partial sum, remaining multiplier bits}; each step adds the
  // multiplicand when the current LSB is set and shifts the pair right.
  assign sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
  assign prod_d = {sum_d, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            if (op == ALU_MUL) begin
              mcand_q <= a;
              prod_q  <= {{WIDTH{1'b0}}, b};
              cnt_q   <= '0;
              state_q <= ST_MUL;
            end else begin
              result_q <= alu_d;
              hi_q     <= '0;
              zero_q   <= (alu_d == '0);
              state_q  <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_q <= prod_d[WIDTH-1:0];
            hi_q     <= prod_d[2*WIDTH-1:WIDTH];
            zero_q   <= (prod_d[WIDTH-1:0] == '0);
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign busy   = (state_q == ST_MUL);
  assign done   = (state_q == ST_DONE);

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised ALU execution unit for the multi-cycle core. It merges ALU-control decoding (aluop/opcode/func) with a registered WIDTH-bit datapath. It adds an iterative unsigned multiplier driven by a start/busy/done handshake.
The main control FSM issues start and waits on done. Every result, including the single-cycle ops, is registered.

Parameters:
WIDTH, 16, datapath width in bits (>=4).
OPC_W, 4, opcode field width.
FUNC_W, 9, func field width (>=8).
ENABLE_MUL, 1, 1 = func[7] decodes MUL; 0 = func[7] ignored, so the priority chain falls through to func[1]/func[0]/default ADD.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
aluop  in  2  class from main control
opcode  in  OPC_W  instruction opcode
func  in  FUNC_W  Type-C function one-hot field
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
result  out  WIDTH  registered result (low half for MUL)
hi  out  WIDTH  upper product half for MUL, else 0
zero  out  1  registered (result == 0)
busy  out  1  high while in MUL state
done  out  1  one-cycle completion pulse

Behaviour:
- Decode (combinational) to 3-bit op: ADD=0, SUB=1, AND=2, OR=3, NOT=4 (~a), PASSA=5, PASSB=6, MUL=7.
- aluop 00:
  - opcode 0010 or 0100 -> PASSB.
  - otherwise -> ADD.
- aluop 01: SUB.
- aluop 10: priority func[2] ADD, [3] SUB, [4] AND, [5] OR, [6] NOT, [7] MUL (if ENABLE_MUL), [1] PASSB, [0] PASSA, else ADD.
- aluop 11:
  - opcode 1100 ADD, 1101 SUB, 1110 AND, 1111 OR.
  - any other opcode -> ADD.
- Arithmetic is modulo 2^WIDTH; no carry or overflow outputs. MUL is unsigned WIDTH x WIDTH -> 2*WIDTH bits.
- FSM states: IDLE, MUL, DONE.
  - IDLE/DONE + start, non-MUL op: compute from a/b and register result/zero at that edge; hi <= 0; next state DONE. Latency: done high the cycle after start.
  - IDLE/DONE + start, MUL op: latch a, b; clear accumulator; cnt <= 0; next state MUL.
  - MUL: one shift-add step per cycle, consuming one multiplier bit (LSB first). After WIDTH steps (cnt == WIDTH-1), load result (low half), hi (high half) and zero; next state DONE. done rises exactly WIDTH+1 cycles after start; busy is high for exactly WIDTH cycles.
  - DONE without start -> IDLE. DONE with start -> back-to-back accept, as in IDLE.
- done = (state == DONE); busy = (state == MUL); both derived from registered state.
- start while in MUL is ignored; the operands in flight are unaffected.
- Changes on a/b/func/opcode/aluop after start do not affect the in-flight op.
- result/hi/zero hold their values until the next completion.
- zero for MUL tests the low half only.
- Reset (rst_n low at an edge): state IDLE, result 0, hi 0, zero 1, busy 0, done 0, cnt 0.
  - Reset mid-MUL aborts the op; no done pulse.
  - Reset has priority over start at the same edge.
- Unknown or zero func under aluop 10 -> ADD; never X.

Decomposition:
- Package alu_pkg holds:
  - op codes ALU_ADD..ALU_MUL;
  - aluop codes ALUOP_MEM, ALUOP_BR, ALUOP_TYPEC, ALUOP_TYPED;
  - opcodes OPC_JUMP=0010, OPC_BRZ=0100, OPC_ADDI..OPC_ORI;
  - func bit indices;
  - state enum.
- Sub-module alu_op_decode (combinational: aluop/opcode/func -> op) keeps decoding testable in isolation. The FSM, multiplier and datapath stay in alu_exec_unit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> result 0x0000, hi 0x0000, zero 1, busy 0, done 0. Assert rst_n=0 on the same edge as start -> stays IDLE.
- aluop=10, func=9'h004, a=0x7FFF, b=0x0001, start -> next cycle done=1, result 0x8000, zero 0. Then aluop=01, a=b=0x1234 back-to-back from DONE -> result 0x0000, zero 1.
- aluop=10, func=9'h080, a=0x0123, b=0x0045 -> busy 16 cycles, done at start+17, result 0x4E6F, hi 0x0000. Then a=b=0xFFFF -> result 0x0001, hi 0xFFFE.
- Mid-MUL: pulse start with func=9'h004 at cycle 3 -> ignored, product unchanged. Separately, rst_n=0 at cycle 5 -> IDLE, no done, outputs reset.
- aluop=11, opcode=1110, a=0x0F0F, b=0x00FF -> result 0x000F. aluop=00, opcode=0100, b=0x0042 -> result 0x0042. aluop=00, opcode=0000, a=0x0002, b=0x0003 -> 0x0005.
- ENABLE_MUL=0 build, func=9'h080 -> single-cycle ADD (a=2, b=3 -> 5). func=9'h000 -> ADD, never X.
